// File: rtl/lrot_8_arb.sv
// lrot_8_arb
//   Two-requester round-robin sequencer for one shared, externally
//   instantiated 8-bit combinational left rotator. An accepted request
//   loads the rotator inputs from registers. One cycle later the
//   rotator result is captured into the response register. The result
//   is then held on a valid/ready port until the consumer takes it.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (0, 1)
//   reqN_data / amt / dir     operand byte, rotate amount, 1 = rotate right
//   rot_data, rot_sel         registered drive of the external rotator
//   rot_out                   rotator result (combinational from rot_*)
//   rsp_valid / rsp_ready     response handshake
//   rsp_data, rsp_id          rotated byte and the requester that issued it
//   busy                      high whenever an operation is in flight
module lrot_8_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    input  logic [2:0] req0_amt,
    input  logic       req0_dir,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    input  logic [2:0] req1_amt,
    input  logic       req1_dir,
    output logic [7:0] rot_data,
    output logic [2:0] rot_sel,
    input  logic [7:0] rot_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       id_q, id_d;
    logic [7:0] rot_data_q, rot_data_d;
    logic [2:0] rot_sel_q, rot_sel_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_valid_q, rsp_valid_d;

    logic       any_valid;
    logic       winner;
    logic       accept;
    logic [7:0] win_data;
    logic [2:0] win_amt;
    logic       win_dir;

    // Arbitration. On a tie the requester that was not granted last wins.
    // With a single valid requester, ~req0_valid selects it directly.
    // Ready depends only on valid, state and rst, never on rsp_ready.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~req0_valid;
        end
        accept     = (state_q == IDLE) && any_valid && !rst;
        req0_ready = accept && !winner;
        req1_ready = accept && winner;
        win_data   = winner ? req1_data : req0_data;
        win_amt    = winner ? req1_amt  : req0_amt;
        win_dir    = winner ? req1_dir  : req0_dir;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rot_data_d   = rot_data_q;
        rot_sel_d    = rot_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rot_data_d   = win_data;
                    // A right rotation by n is a left rotation by (8 - n) mod 8;
                    // 3-bit wraparound of 0 - n gives exactly that.
                    rot_sel_d    = win_dir ? (3'd0 - win_amt) : win_amt;
                    id_d         = winner;
                    last_grant_d = winner;
                    state_d      = ROT;
                end
            end
            ROT: begin
                rsp_data_d  = rot_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rot_data_q   <= 8'h00;
            rot_sel_q    <= 3'd0;
            rsp_data_q   <= 8'h00;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rot_data_q   <= rot_data_d;
            rot_sel_q    <= rot_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rot_data  = rot_data_q;
    assign rot_sel   = rot_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lrot_8_arb.sv
module tb_lrot_8_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic [7:0] rot_data, rot_out, rsp_data;
    logic [2:0] rot_sel;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rot_dbl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External rotator: combinational left rotate of rot_data by rot_sel.
    assign rot_dbl = {rot_data, rot_data} << rot_sel;
    assign rot_out = rot_dbl[15:8];

    lrot_8_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rot_data(rot_data), .rot_sel(rot_sel), .rot_out(rot_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Bit-level rotation straight from the definition: left moves bit i to
    // i+amt, right moves bit i to i-amt, both modulo 8.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input int amt, input logic dir);
        logic [7:0] o;
        o = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (dir) o[(i + 8 - amt) % 8] = d[i];
            else     o[(i + amt) % 8]     = d[i];
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy0"}, {7'd0, req0_ready}, 8'd0);
        chk({tag, "_rdy1"}, {7'd0, req1_ready}, 8'd0);
        chk({tag, "_rspv"}, {7'd0, rsp_valid}, 8'd0);
        chk({tag, "_rspd"}, rsp_data, 8'h00);
        chk({tag, "_rspid"}, {7'd0, rsp_id}, 8'd0);
        chk({tag, "_rotd"}, rot_data, 8'h00);
        chk({tag, "_rots"}, {5'd0, rot_sel}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    // Called at posedge+1 with the requests already driven; returns at
    // posedge+1 once the operation has completed and the block is idle.
    task automatic run_op(input int r, input logic keep, input logic [2:0] esel,
                          input logic [7:0] edata, input logic [7:0] eres);
        rsp_ready = 1'b1;
        #1;
        chk("op_ready_win",  {7'd0, (r == 0) ? req0_ready : req1_ready}, 8'd1);
        chk("op_ready_lose", {7'd0, (r == 0) ? req1_ready : req0_ready}, 8'd0);
        tick();
        if (!keep) begin
            if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        #1;
        chk("op_rot_busy", {7'd0, busy}, 8'd1);
        chk("op_rot_sel", {5'd0, rot_sel}, {5'd0, esel});
        chk("op_rot_data", rot_data, edata);
        chk("op_rot_rspv", {7'd0, rsp_valid}, 8'd0);
        chk("op_rot_rdy", {6'd0, req1_ready, req0_ready}, 8'd0);
        tick();
        chk("op_rsp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("op_rsp_data", rsp_data, eres);
        chk("op_rsp_id", {7'd0, rsp_id}, r[7:0]);
        tick();
        chk("op_done_busy", {7'd0, busy}, 8'd0);
        chk("op_done_rspv", {7'd0, rsp_valid}, 8'd0);
    endtask

    logic [7:0] pd [2];
    logic [2:0] pa [2];
    logic       pdir [2];
    logic [1:0] pend;
    int         m_phase, m_last, w;
    logic       anyv;
    logic [7:0] m_dat, m_res;
    logic [2:0] m_sel;
    logic       m_id;

    initial begin
        // Reset held with both requesters valid.
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 3'd3; req1_dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_vals("rst");
        end
        rst = 1'b0;

        // First tie after reset goes to requester 0; then requester 1.
        run_op(0, 1'b0, 3'd1, 8'h81, 8'h03);
        run_op(1, 1'b0, 3'd5, 8'h01, 8'h20);
        req1_valid = 1'b1; req1_data = 8'hB4; req1_amt = 3'd0; req1_dir = 1'b1;
        run_op(1, 1'b0, 3'd0, 8'hB4, 8'hB4);

        // Fairness with both requesters continuously valid.
        req0_valid = 1'b1; req0_data = 8'h0F; req0_amt = 3'd2; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hF0; req1_amt = 3'd1; req1_dir = 1'b1;
        run_op(0, 1'b1, 3'd2, 8'h0F, 8'h3C);
        run_op(1, 1'b1, 3'd7, 8'hF0, 8'h78);
        run_op(0, 1'b1, 3'd2, 8'h0F, 8'h3C);
        run_op(1, 1'b0, 3'd7, 8'hF0, 8'h78);
        req0_valid = 1'b0;

        // Backpressure: response held for 5 cycles with both requesters valid.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h12; req0_amt = 3'd4; req0_dir = 1'b1;
        #1;
        chk("bp_ready0", {7'd0, req0_ready}, 8'd1);
        tick();
        req1_valid = 1'b1; req1_data = 8'h77; req1_amt = 3'd0; req1_dir = 1'b0;
        #1;
        chk("bp_rot_sel", {5'd0, rot_sel}, 8'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", {7'd0, rsp_valid}, 8'd1);
            chk("bp_rspd", rsp_data, 8'h21);
            chk("bp_rspid", {7'd0, rsp_id}, 8'd0);
            chk("bp_rdy", {6'd0, req1_ready, req0_ready}, 8'd0);
            chk("bp_busy", {7'd0, busy}, 8'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hold_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("bp_idle_busy", {7'd0, busy}, 8'd0);
        chk("bp_idle_rspv", {7'd0, rsp_valid}, 8'd0);
        chk("bp_idle_rdy", {6'd0, req1_ready, req0_ready}, 8'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during ROT.
        req0_valid = 1'b1; req0_data = 8'h3C; req0_amt = 3'd2; req0_dir = 1'b0;
        tick();
        req0_valid = 1'b0;
        chk("mr_rot_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("mr_rot");
        tick();
        rst = 1'b0;
        tick();
        chk("mr_rot_norsp", {7'd0, rsp_valid}, 8'd0);
        chk("mr_rot_idle", {7'd0, busy}, 8'd0);
        req0_valid = 1'b1; req0_data = 8'hC3; req0_amt = 3'd2; req0_dir = 1'b1;
        run_op(0, 1'b0, 3'd6, 8'hC3, 8'hF0);

        // Reset during RESP.
        req0_valid = 1'b1; req0_data = 8'h3C; req0_amt = 3'd2; req0_dir = 1'b0;
        rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("mr_resp_rspd", rsp_data, 8'hF0);
        rst = 1'b1;
        #1;
        chk_reset_vals("mr_resp");
        tick();
        rst = 1'b0;
        tick();
        chk("mr_resp_norsp", {7'd0, rsp_valid}, 8'd0);
        req0_valid = 1'b1; req0_data = 8'h80; req0_amt = 3'd7; req0_dir = 1'b0;
        run_op(0, 1'b0, 3'd7, 8'h80, 8'h40);

        // Randomized traffic against a transaction-level model.
        m_phase = 0; m_last = 0; pend = 2'b00;
        m_dat = 8'h00; m_res = 8'h00; m_sel = 3'd0; m_id = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pd[r]   = 8'($urandom_range(0, 255));
                    pa[r]   = 3'($urandom_range(0, 7));
                    pdir[r] = 1'($urandom_range(0, 1));
                end
            end
            req0_valid = pend[0]; req0_data = pd[0]; req0_amt = pa[0]; req0_dir = pdir[0];
            req1_valid = pend[1]; req1_data = pd[1]; req1_amt = pa[1]; req1_dir = pdir[1];
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            anyv = pend[0] | pend[1];
            w = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
            chk("rnd_busy", {7'd0, busy}, {7'd0, m_phase != 0});
            if (m_phase == 0) begin
                chk("rnd_rdy0", {7'd0, req0_ready}, {7'd0, anyv && w == 0});
                chk("rnd_rdy1", {7'd0, req1_ready}, {7'd0, anyv && w == 1});
                chk("rnd_idle_rspv", {7'd0, rsp_valid}, 8'd0);
            end else begin
                chk("rnd_busy_rdy", {6'd0, req1_ready, req0_ready}, 8'd0);
            end
            if (m_phase == 1) begin
                chk("rnd_rot_sel", {5'd0, rot_sel}, {5'd0, m_sel});
                chk("rnd_rot_data", rot_data, m_dat);
                chk("rnd_rot_rspv", {7'd0, rsp_valid}, 8'd0);
            end
            if (m_phase == 2) begin
                chk("rnd_rspv", {7'd0, rsp_valid}, 8'd1);
                chk("rnd_rspd", rsp_data, m_res);
                chk("rnd_rspid", {7'd0, rsp_id}, {7'd0, m_id});
            end
            case (m_phase)
                0: if (anyv) begin
                    pend[w] = 1'b0;
                    m_dat   = pd[w];
                    m_sel   = 3'((pdir[w] ? (8 - int'(pa[w])) : int'(pa[w])) % 8);
                    m_res   = rot_ref(pd[w], int'(pa[w]), pdir[w]);
                    m_id    = (w == 1);
                    m_last  = w;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) m_phase = 0;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lrot_8_arb.md
# lrot_8_arb

Round-robin arbiter and sequencer that shares a single 8-bit combinational left rotator between two requesters. Each requester submits a byte, a 3-bit amount and a direction. The block converts right rotations to the equivalent left amount, drives the rotator's data and select inputs from registers, and captures the result. It returns the result on a valid/ready response port tagged with the requester id. It sits between client logic and one externally instantiated 8-bit left rotator.

## Interface
Parameters: none. Width is fixed at 8 data bits and 3 select bits; requester count is fixed at 2.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_data  input  8  operand byte
- req0_amt  input  3  rotation amount, 0..7
- req0_dir  input  1  0 = rotate left, 1 = rotate right
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same as requester 0, for requester 1
- rot_data  output  8  to rotator data input (registered)
- rot_sel  output  3  to rotator select input (registered; left-rotate amount)
- rot_out  input  8  rotator result (combinational from rot_data/rot_sel)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  8  rotated byte
- rsp_id  output  1  requester that issued the result
- busy  output  1  high whenever state != IDLE

## Operation
- **States:**
  - IDLE: no operation held.
  - ROT: rotator inputs are driven from registers.
  - RESP: result is held until the consumer takes it.
- **IDLE:**
  - Arbitrate among the requesters whose valid is high.
  - If exactly one is valid, it wins.
  - If both are valid, the winner is the one that is not last_grant.
  - The winner's ready is asserted combinationally. Ready is never asserted outside IDLE, during rst, or for a requester whose valid is low.
  - Acceptance occurs on valid&&ready. At that edge:
    - rot_data <= data.
    - rot_sel <= dir ? (0 - amt) mod 8 : amt (3-bit wrap).
    - id register <= winner.
    - last_grant <= winner.
    - state -> ROT.
- **ROT:** unconditionally, rsp_data <= rot_out, rsp_id <= id, rsp_valid <= 1, state -> RESP.
- **RESP:**
  - rsp_data and rsp_id are stable while rsp_valid=1.
  - On rsp_valid&&rsp_ready: rsp_valid <= 0, state -> IDLE.
- **Requester rules:**
  - A requester must hold valid, data, amt and dir stable until it sees ready.
  - The block does not latch unaccepted requests.
- **Boundary conditions:**
  - amt=0 in either direction gives rot_sel=0, so the data passes unchanged.
  - Right by 4 gives rot_sel=4.
- rot_data and rot_sel keep their last values outside ROT.
- **Reset** (any state, including mid-operation):
  - state=IDLE.
  - rsp_valid=0, rsp_data=0x00, rsp_id=0.
  - rot_data=0x00, rot_sel=0.
  - last_grant=1, so requester 0 wins the first tie.
  - busy=0, both readies 0.
  - An in-flight operation is discarded and no response is produced.

## Timing
- Accept at edge E0.
- rot_data/rot_sel are valid during the E0..E1 cycle.
- rsp_valid is high after E1 (latency 2 edges).
- Earliest completion is at E2 with rsp_ready=1. The next accept is at E3, so peak throughput is one operation per 3 cycles.
- The rotator path (rot_data/rot_sel -> rot_out -> rsp_data) is a full single-cycle path.
- Ready depends combinationally on valid and state only; it has no path from rsp_ready.
- Back-to-back ties alternate strictly: 0, 1, 0, 1.

## Test plan
- **Reset values:** assert rst for 3 cycles with both valids high. Required: both readies 0, rsp_valid 0, rsp_data 0x00, rot_sel 0, busy 0. After release, req0 is granted first.
- **Left rotate:** req0 data 0x81, amt 1, dir 0, rsp_ready=1.
  - rot_sel=1 during ROT.
  - rsp_valid rises 2 edges after accept with rsp_data 0x03, rsp_id 0.
  - Next accept is possible 3 cycles after the first.
- **Right rotate:** req1 data 0x01, amt 3, dir 1. Required: rot_sel=5, rsp_data 0x20, rsp_id 1. Also check req1 data 0xB4, amt 0, dir 1: rot_sel=0, rsp_data 0xB4.
- **Fairness:** both requesters hold valid continuously for 4 operations.
  - Grant order is 0, 1, 0, 1 and rsp_id follows that order.
  - Each requester's ready pulses exactly once per accepted operation.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP with req0 and req1 valid. Required:
  - rsp_valid, rsp_data and rsp_id are stable.
  - No ready is asserted and busy=1.
  - IDLE is entered one edge after rsp_ready rises.
- **Reset mid-operation:** assert rst during ROT, then separately during RESP. Required:
  - Immediate (asynchronous) return to reset values, with no response produced.
  - After release, a new req0 operation completes normally.
